// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage: DATA_W payload register with valid/ready handshake,
// a 2-entry skid buffer and flush/freeze controls. Optional counters: PIPE_STAGE_STATS_EN.
module pipe_stage_elastic #(
    parameter int                 DATA_W    = 32,
    parameter logic [DATA_W-1:0]  CLEAR_VAL = '0
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              flush,
    input  logic              freeze,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       bubble_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] r_skid;
    logic              w_push;
    logic              w_pop;

    // Handshake depends only on registered state and freeze, so in_ready
    // never sees out_ready combinationally.
    assign in_ready  = !freeze && (r_state != FULL);
    assign out_valid = !freeze && (r_state != EMPTY);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;
    assign out_data  = r_main;
    assign occupancy = r_state;

    always_ff @(posedge CLK) begin
        if (!nRST || flush) begin
            r_state <= EMPTY;
            r_main  <= CLEAR_VAL;
            r_skid  <= CLEAR_VAL;
        end else if (!freeze) begin
            case (r_state)
                EMPTY: begin
                    if (w_push) begin
                        r_state <= ONE;
                        r_main  <= in_data;
                    end
                end
                ONE: begin
                    case ({w_push, w_pop})
                        2'b10: begin
                            r_state <= FULL;
                            r_skid  <= in_data;
                        end
                        2'b01: r_state <= EMPTY;
                        2'b11: r_main  <= in_data;
                        default: ;
                    endcase
                end
                FULL: begin
                    if (w_pop) begin
                        r_state <= ONE;
                        r_main  <= r_skid;
                    end
                end
                default: r_state <= EMPTY;
            endcase
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    logic [15:0] r_stall_cnt;
    logic [15:0] r_bubble_cnt;

    // Counters survive flush; only reset clears them. Both saturate.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if ((r_state != EMPTY) && !out_ready && !freeze && (r_stall_cnt != 16'hFFFF))
                r_stall_cnt <= r_stall_cnt + 16'd1;
            if ((r_state == EMPTY) && out_ready && !freeze && (r_bubble_cnt != 16'hFFFF))
                r_bubble_cnt <= r_bubble_cnt + 16'd1;
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Self-checking bench for pipe_stage_elastic: directed scenarios plus a
// randomized run against a queue-based FIFO model.
module tb_pipe_stage_elastic;

    localparam int          W   = 32;
    localparam logic [W-1:0] CLR = 32'h0BAD_F00D;

    logic         CLK = 1'b0;
    logic         nRST;
    logic         flush;
    logic         freeze;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [1:0]   occupancy;
`ifdef PIPE_STAGE_STATS_EN
    logic [15:0]  stall_cnt;
    logic [15:0]  bubble_cnt;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    // Model: payloads held, in arrival order; m_last = what the output register shows when empty.
    logic [W-1:0] q[$];
    logic [W-1:0] m_last;

    always #5 CLK = ~CLK;

    pipe_stage_elastic #(.DATA_W(W), .CLEAR_VAL(CLR)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .flush     (flush),
        .freeze    (freeze),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
`ifdef PIPE_STAGE_STATS_EN
        ,
        .stall_cnt (stall_cnt),
        .bubble_cnt(bubble_cnt)
`endif
    );

    function automatic void model_edge();
        logic p, po;
        if (!nRST || flush) begin
            q.delete();
            m_last = CLR;
        end else if (!freeze) begin
            p  = in_valid && (q.size() < 2);
            po = out_ready && (q.size() > 0);
            if (po) m_last = q.pop_front();
            if (p)  q.push_back(in_data);
        end
    endfunction

    function automatic logic [W-1:0] exp_data();
        return (q.size() > 0) ? q[0] : m_last;
    endfunction

    // Apply inputs, advance one edge, update the model, settle away from the edge.
    task automatic tick(input logic iv, input logic [W-1:0] d, input logic ordy,
                        input logic frz, input logic fl);
        in_valid = iv; in_data = d; out_ready = ordy; freeze = frz; flush = fl;
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        tick(1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
        nRST = 1'b1;
        in_valid = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        tests_run++;
        if (occupancy !== 2'd0) begin tests_failed++; $display("FAIL reset_occupancy: got %0d expected 0", occupancy); end
        tests_run++;
        if (out_data !== CLR) begin tests_failed++; $display("FAIL reset_out_data: got %h expected %h", out_data, CLR); end
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        $display("[TB] reset: occ=%0d out_valid=%b in_ready=%b out_data=%h", occupancy, out_valid, in_ready, out_data);
    endtask

    task automatic test_streaming();
        logic [W-1:0] vals [3] = '{32'hA, 32'hB, 32'hC};
        tick(1'b0, '0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, vals[i], 1'b1, 1'b0, 1'b0);
            tests_run++;
            if (out_valid !== 1'b1 || out_data !== vals[i] || occupancy !== 2'd1) begin
                tests_failed++;
                $display("FAIL stream_%0d: got v=%b d=%h occ=%0d expected v=1 d=%h occ=1",
                         i, out_valid, out_data, occupancy, vals[i]);
            end
            $display("[TB] stream push %h -> out_data=%h occ=%0d", vals[i], out_data, occupancy);
        end
        tick(1'b0, '0, 1'b1, 1'b0, 1'b0);
        tests_run++;
        if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL stream_drain: got occ=%0d v=%b expected occ=0 v=0", occupancy, out_valid);
        end
    endtask

    task automatic test_backpressure();
        tick(1'b0, '0, 1'b0, 1'b0, 1'b1);
        tick(1'b1, 32'h11, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 32'h22, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 32'h11) begin
            tests_failed++;
            $display("FAIL bp_full: got occ=%0d in_ready=%b d=%h expected occ=2 in_ready=0 d=11",
                     occupancy, in_ready, out_data);
        end
        // A third push while full must be refused.
        tick(1'b1, 32'h33, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (occupancy !== 2'd2 || out_data !== 32'h11) begin
            tests_failed++;
            $display("FAIL bp_hold: got occ=%0d d=%h expected occ=2 d=11", occupancy, out_data);
        end
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 32'h11) begin
            tests_failed++;
            $display("FAIL bp_first: got v=%b d=%h expected v=1 d=11", out_valid, out_data);
        end
        tick(1'b0, '0, 1'b1, 1'b0, 1'b0);
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 32'h22 || occupancy !== 2'd1) begin
            tests_failed++;
            $display("FAIL bp_second: got v=%b d=%h occ=%0d expected v=1 d=22 occ=1",
                     out_valid, out_data, occupancy);
        end
        tick(1'b0, '0, 1'b1, 1'b0, 1'b0);
        tests_run++;
        if (occupancy !== 2'd0) begin tests_failed++; $display("FAIL bp_drain: got occ=%0d expected 0", occupancy); end
        $display("[TB] backpressure: drained 11 then 22, occ=%0d", occupancy);
    endtask

    task automatic test_freeze();
        tick(1'b0, '0, 1'b0, 1'b0, 1'b1);
        tick(1'b1, 32'h11, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 32'h22, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 32'h99, 1'b1, 1'b1, 1'b0);
            tests_run++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0 || occupancy !== 2'd2) begin
                tests_failed++;
                $display("FAIL freeze_%0d: got in_ready=%b v=%b occ=%0d expected 0 0 2",
                         i, in_ready, out_valid, occupancy);
            end
        end
        freeze = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 32'h11 || in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL freeze_release: got v=%b d=%h in_ready=%b expected v=1 d=11 in_ready=0",
                     out_valid, out_data, in_ready);
        end
        $display("[TB] freeze released: out_data=%h occ=%0d", out_data, occupancy);
    endtask

    task automatic test_flush();
        tick(1'b0, '0, 1'b0, 1'b0, 1'b1);
        tick(1'b1, 32'h11, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 32'h22, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 32'h55, 1'b0, 1'b0, 1'b1);
        tests_run++;
        if (occupancy !== 2'd0 || out_data !== CLR || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush: got occ=%0d d=%h v=%b expected occ=0 d=%h v=0",
                     occupancy, out_data, out_valid, CLR);
        end
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, '0, 1'b1, 1'b0, 1'b0);
            tests_run++;
            if (out_valid !== 1'b0 || out_data === 32'h55) begin
                tests_failed++;
                $display("FAIL flush_ghost_%0d: got v=%b d=%h expected v=0 and no 55", i, out_valid, out_data);
            end
        end
        $display("[TB] flush: occ=%0d out_data=%h", occupancy, out_data);
    endtask

    task automatic test_random();
        logic iv, ordy, frz, fl;
        logic [W-1:0] d;
        int errs = 0;
        for (int i = 0; i < 600; i++) begin
            iv   = ($urandom_range(0, 3) != 0);
            d    = $urandom;
            ordy = ($urandom_range(0, 2) != 0);
            frz  = ($urandom_range(0, 7) == 0);
            fl   = ($urandom_range(0, 40) == 0);
            nRST = ($urandom_range(0, 80) != 0);
            tick(iv, d, ordy, frz, fl);
            tests_run++;
            if (in_ready !== (!freeze && q.size() < 2) || out_valid !== (!freeze && q.size() > 0) ||
                occupancy !== 2'(q.size()) || out_data !== exp_data()) begin
                tests_failed++;
                errs++;
                $display("FAIL random_%0d: got rdy=%b v=%b occ=%0d d=%h expected rdy=%b v=%b occ=%0d d=%h",
                         i, in_ready, out_valid, occupancy, out_data,
                         (!freeze && q.size() < 2), (!freeze && q.size() > 0), q.size(), exp_data());
            end
        end
        nRST = 1'b1;
        $display("[TB] random: 600 cycles, %0d mismatching", errs);
    endtask

`ifdef PIPE_STAGE_STATS_EN
    task automatic test_stats();
        nRST = 1'b0;
        tick(1'b0, '0, 1'b0, 1'b0, 1'b0);
        nRST = 1'b1;
        tick(1'b1, 32'h77, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) tick(1'b0, '0, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (stall_cnt !== 16'd5) begin tests_failed++; $display("FAIL stall_cnt: got %0d expected 5", stall_cnt); end
        tick(1'b0, '0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) tick(1'b0, '0, 1'b1, 1'b0, 1'b0);
        tests_run++;
        if (bubble_cnt !== 16'd3) begin tests_failed++; $display("FAIL bubble_cnt: got %0d expected 3", bubble_cnt); end
        tests_run++;
        if (stall_cnt !== 16'd5) begin tests_failed++; $display("FAIL stall_after_flush: got %0d expected 5", stall_cnt); end
        $display("[TB] stats: stall=%0d bubble=%0d", stall_cnt, bubble_cnt);
    endtask
`endif

    initial begin
        nRST = 1'b0; flush = 1'b0; freeze = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        m_last = CLR;
        #2;
        test_reset();
        test_streaming();
        test_backpressure();
        test_freeze();
        test_flush();
        test_random();
`ifdef PIPE_STAGE_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Parametrised successor to the fixed-field inter-stage latch.
- Generic DATA_W-wide pipeline stage register with valid/ready handshake and a 2-entry skid buffer; keeps the existing flush/freeze hazard controls.
- Sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). The stage's control/datapath fields are packed into in_data by the instantiating stage.
- Decouples upstream back-pressure: in_ready depends only on registered state and freeze, never on out_ready.

Parameters:
- DATA_W, 32, width of the packed stage payload.
- CLEAR_VAL, '0 (DATA_W bits), bubble value loaded into both data registers on reset/flush.

Ports:
- CLK  input  1  clock, rising edge.
- nRST  input  1  synchronous active-low reset; sampled on CLK rising edge.
- flush  input  1  discard all held entries next edge (hazard unit).
- freeze  input  1  stall: no transfer on either side this cycle.
- in_valid  input  1  upstream has a payload.
- in_ready  output  1  stage can accept (= !freeze && state != FULL).
- in_data  input  DATA_W  upstream payload.
- out_valid  output  1  payload available (= !freeze && state != EMPTY).
- out_ready  input  1  downstream accepts.
- out_data  output  DATA_W  main register contents.
- occupancy  output  2  entries held: 0, 1 or 2.

Behaviour:
- State register: EMPTY(0), ONE(1), FULL(2); occupancy = state encoding.
- Storage: main_q (drives out_data) and skid_q.
- push = in_valid && in_ready; pop = out_valid && out_ready. Both are 0 while freeze=1.
- Priority per edge: nRST=0 > flush=1 > freeze=1 > normal transitions.
- Reset (nRST=0 at edge): state=EMPTY, main_q=skid_q=CLEAR_VAL.
  - Reset outputs: in_ready=!freeze, out_valid=0, out_data=CLEAR_VAL, occupancy=0.
  - Reset mid-transfer drops all data; no partial payload survives.
- Flush: same register effect as reset. A simultaneous push is discarded; a simultaneous pop is still seen by downstream in that cycle.
- Freeze: state, main_q and skid_q hold. in_ready=0 and out_valid=0 combinationally.
- EMPTY:
  - push -> ONE, main_q<=in_data.
  - no push -> stay.
- ONE:
  - push && !pop -> FULL, skid_q<=in_data.
  - pop && !push -> EMPTY, main_q unchanged (stale value allowed).
  - push && pop -> ONE, main_q<=in_data.
  - neither -> hold.
- FULL:
  - in_ready=0, so no push is possible.
  - pop -> ONE, main_q<=skid_q.
  - no pop -> hold (back-pressure).
- Ordering: strict FIFO; a payload is never duplicated or reordered.
- Latency: 1 cycle from push to out_valid. Full throughput: 1 transfer/cycle when out_ready stays high.
- in_ready never combinationally depends on out_ready or in_valid.

Optional Feature:
- Macro: PIPE_STAGE_STATS_EN.
- Defined: adds two outputs, stall_cnt[15:0] and bubble_cnt[15:0].
  - stall_cnt increments each cycle with state!=EMPTY && !out_ready && !freeze.
  - bubble_cnt increments each cycle with out_ready && state==EMPTY && !freeze.
  - Both saturate at 16'hFFFF.
  - Both clear on nRST only; flush does not clear them.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset with nRST=0 for 2 edges -> out_valid=0, occupancy=0, out_data=CLEAR_VAL, in_ready=1.
- Streaming: push 0xA, 0xB, 0xC on consecutive cycles, out_ready=1 -> out_data 0xA, 0xB, 0xC each one cycle after push; occupancy stays 1; no gaps.
- Back-pressure: out_ready=0, push 0x11 then 0x22 -> occupancy=2, in_ready=0. Raise out_ready -> 0x11 then 0x22 appear in order.
- Freeze: state FULL, freeze=1 for 3 cycles with out_ready=1 -> in_ready=0, out_valid=0, occupancy stays 2. Release -> 0x11 appears.
- Flush with FULL and push asserted (in_data=0x55) -> next cycle occupancy=0, out_data=CLEAR_VAL; 0x55 never appears.
- Stats build (PIPE_STAGE_STATS_EN): hold one entry with out_ready=0 for 5 cycles -> stall_cnt=5. Flush, then assert out_ready on empty for 3 cycles -> bubble_cnt=3, stall_cnt still 5.
